// File: rtl/sdf_bf8_stage.sv
// ---------------------------------------------------------------------------
// sdf_bf8_stage
//   Datapath of FFT stage 2 (radix-2 single-path delay feedback, span 8).
//   It is driven directly by the stage-2 controller. For each frame it
//   produces 16 samples: g[n] = x[n] + x[n+8] (n = 0..7), then
//   h[n] = (x[n] - x[n+8]) * WN.
//
//   Frame timing as the controller drives it:
//     WAITING x8 : x[0..7] are loaded into the delay line
//     FIRST   x8 : g[n] is emitted and x[n]-x[n+8] is fed back
//     SECOND  x8 : h[n] is emitted and the next frame's first half is loaded
//
//   Configuration macro: BF8_SAT_EN
//     defined   - add/sub/multiply results clamp to the DW range; any clamp
//                 sets the sticky ovf_o flag.
//     undefined - results wrap (low DW bits kept); ovf_o is tied to 0.
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous reset, active-high
//   state_i  [1:0]  controller state: 00 IDLE, 01 FIRST, 10 SECOND, 11 WAITING
//   a_r/a_i  [DW]   incoming sample, signed
//   wn_r/wn_i [TW]  twiddle, signed, TW_FRAC fractional bits (used in SECOND)
//   dout_r/dout_i   registered butterfly result, signed
//   valid_o         dout holds a valid g/h sample
//   idx_o           output index within the frame, 0..2*DEPTH-1
//   ovf_o           sticky overflow flag (saturating build only)
//   err_o           sticky protocol error
// ---------------------------------------------------------------------------
module sdf_bf8_stage #(
    parameter int  DW      = 14,
    parameter int  TW      = 8,
    parameter int  TW_FRAC = 6,
    parameter int  DEPTH   = 8,
    localparam int IW      = $clog2(2 * DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    state_i,
    input  logic [DW-1:0] a_r,
    input  logic [DW-1:0] a_i,
    input  logic [TW-1:0] wn_r,
    input  logic [TW-1:0] wn_i,
    output logic [DW-1:0] dout_r,
    output logic [DW-1:0] dout_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o,
    output logic          ovf_o,
    output logic          err_o
);

    // Full product width: DW x TW signed products plus one bit for the sum.
    localparam int                     PW        = DW + TW + 1;
    localparam int                     FW        = $clog2(DEPTH + 1);
    localparam logic [FW-1:0]          FILL_FULL = FW'(DEPTH);
    localparam logic signed [PW-1:0]   RND       = PW'(2 ** (TW_FRAC - 1));

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_FIRST   = 2'b01,
        ST_SECOND  = 2'b10,
        ST_WAITING = 2'b11
    } state_e;

    state_e st;
    state_e prev_st_q, prev_st_d;

    // Delay line, entry 0 is the head (oldest sample).
    logic [DW-1:0] dl_r_q [DEPTH];
    logic [DW-1:0] dl_i_q [DEPTH];
    logic [DW-1:0] dl_r_d [DEPTH];
    logic [DW-1:0] dl_i_d [DEPTH];

    logic [FW-1:0] fill_q, fill_d;
    logic [DW-1:0] dout_r_q, dout_r_d, dout_i_q, dout_i_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          err_q, err_d;

    // Wide arithmetic results and their DW-bit reductions.
    logic signed [PW-1:0] sum_r_w, sum_i_w, dif_r_w, dif_i_w, prd_r_w, prd_i_w;
    logic [DW-1:0]        sum_r_n, sum_i_n, dif_r_n, dif_i_n, prd_r_n, prd_i_n;
    logic [DW-1:0]        push_r, push_i;

    function automatic logic signed [PW-1:0] sx_d(input logic [DW-1:0] x);
        return {{(PW - DW){x[DW-1]}}, x};
    endfunction

    function automatic logic signed [PW-1:0] sx_t(input logic [TW-1:0] x);
        return {{(PW - TW){x[TW-1]}}, x};
    endfunction

    assign st = state_e'(state_i);

    // Butterfly and rounded complex multiply on the delay-line head.
    always_comb begin
        sum_r_w = sx_d(dl_r_q[0]) + sx_d(a_r);
        sum_i_w = sx_d(dl_i_q[0]) + sx_d(a_i);
        dif_r_w = sx_d(dl_r_q[0]) - sx_d(a_r);
        dif_i_w = sx_d(dl_i_q[0]) - sx_d(a_i);
        prd_r_w = (sx_d(dl_r_q[0]) * sx_t(wn_r) - sx_d(dl_i_q[0]) * sx_t(wn_i) + RND) >>> TW_FRAC;
        prd_i_w = (sx_d(dl_r_q[0]) * sx_t(wn_i) + sx_d(dl_i_q[0]) * sx_t(wn_r) + RND) >>> TW_FRAC;
    end

`ifdef BF8_SAT_EN
    localparam logic signed [PW-1:0] MAX_V = PW'(2 ** (DW - 1) - 1);
    localparam logic signed [PW-1:0] MIN_V = ~MAX_V;

    logic ovf_q, ovf_d;
    logic clip_sum, clip_dif, clip_prd;

    function automatic logic [DW-1:0] sat(input logic signed [PW-1:0] v);
        if (v > MAX_V) return MAX_V[DW-1:0];
        if (v < MIN_V) return MIN_V[DW-1:0];
        return v[DW-1:0];
    endfunction

    function automatic logic clip(input logic signed [PW-1:0] v);
        return (v > MAX_V) || (v < MIN_V);
    endfunction

    always_comb begin
        sum_r_n  = sat(sum_r_w);
        sum_i_n  = sat(sum_i_w);
        dif_r_n  = sat(dif_r_w);
        dif_i_n  = sat(dif_i_w);
        prd_r_n  = sat(prd_r_w);
        prd_i_n  = sat(prd_i_w);
        clip_sum = clip(sum_r_w) || clip(sum_i_w);
        clip_dif = clip(dif_r_w) || clip(dif_i_w);
        clip_prd = clip(prd_r_w) || clip(prd_i_w);
        // Only clamps on results that are actually used count as overflow.
        ovf_d    = ovf_q
                 || ((st == ST_FIRST)  && (clip_sum || clip_dif))
                 || ((st == ST_SECOND) && clip_prd);
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf_o = ovf_q;
`else
    always_comb begin
        sum_r_n = sum_r_w[DW-1:0];
        sum_i_n = sum_i_w[DW-1:0];
        dif_r_n = dif_r_w[DW-1:0];
        dif_i_n = dif_i_w[DW-1:0];
        prd_r_n = prd_r_w[DW-1:0];
        prd_i_n = prd_i_w[DW-1:0];
    end

    // Upper bits are deliberately discarded when wrapping.
    logic unused_hi;
    assign unused_hi = ^{sum_r_w[PW-1:DW], sum_i_w[PW-1:DW], dif_r_w[PW-1:DW],
                         dif_i_w[PW-1:DW], prd_r_w[PW-1:DW], prd_i_w[PW-1:DW]};

    assign ovf_o = 1'b0;
`endif

    // Next-state logic: delay line, fill count, output register, index, error.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        dl_r_d    = dl_r_q;
        dl_i_d    = dl_i_q;
        fill_d    = fill_q;
        prev_st_d = st;
        dout_r_d  = '0;
        dout_i_d  = '0;
        valid_d   = 1'b0;
        err_d     = err_q;
        push_r    = a_r;
        push_i    = a_i;

        if ((st == ST_FIRST) && (fill_q < FILL_FULL)) err_d = 1'b1;
        if ((st == ST_SECOND) && (prev_st_q != ST_FIRST) && (prev_st_q != ST_SECOND))
            err_d = 1'b1;

        case (st)
            ST_FIRST: begin
                dout_r_d = sum_r_n;
                dout_i_d = sum_i_n;
                valid_d  = 1'b1;
                // The difference waits one span in the line to be twiddled.
                push_r   = dif_r_n;
                push_i   = dif_i_n;
            end
            ST_SECOND: begin
                dout_r_d = prd_r_n;
                dout_i_d = prd_i_n;
                valid_d  = 1'b1;
            end
            default: ;
        endcase

        if (st == ST_IDLE) begin
            fill_d = '0;
        end else begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                dl_r_d[k] = dl_r_q[k + 1];
                dl_i_d[k] = dl_i_q[k + 1];
            end
            dl_r_d[DEPTH-1] = push_r;
            dl_i_d[DEPTH-1] = push_i;
            if (fill_q < FILL_FULL) fill_d = fill_q + FW'(1);
        end

        // Index restarts at 0 on the first valid sample after a gap.
        idx_d = (valid_d && valid_q) ? idx_q + IW'(1) : '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            // NOTE: the delay line is reset so an aborted frame leaves no stale samples.
            for (int k = 0; k < DEPTH; k++) begin
                dl_r_q[k] <= '0;
                dl_i_q[k] <= '0;
            end
            fill_q    <= '0;
            prev_st_q <= ST_IDLE;
            dout_r_q  <= '0;
            dout_i_q  <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            dl_r_q    <= dl_r_d;
            dl_i_q    <= dl_i_d;
            fill_q    <= fill_d;
            prev_st_q <= prev_st_d;
            dout_r_q  <= dout_r_d;
            dout_i_q  <= dout_i_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
        end
    end

    assign dout_r  = dout_r_q;
    assign dout_i  = dout_i_q;
    assign valid_o = valid_q;
    assign idx_o   = idx_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_sdf_bf8_stage.sv
// ---------------------------------------------------------------------------
// tb_sdf_bf8_stage
//   Self-checking bench for sdf_bf8_stage. A behavioural model (a queue as
//   the delay line, integer arithmetic for the butterfly) predicts every
//   output after every clock; directed frames additionally compare against
//   hand-computed constants.
// ---------------------------------------------------------------------------
module tb_sdf_bf8_stage;

    localparam int DW = 14;
    localparam int TW = 8;
    localparam int S_IDLE = 0, S_FIRST = 1, S_SECOND = 2, S_WAIT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    state_i;
    logic [DW-1:0] a_r, a_i;
    logic [TW-1:0] wn_r, wn_i;
    logic [DW-1:0] dout_r, dout_i;
    logic          valid_o;
    logic [3:0]    idx_o;
    logic          ovf_o, err_o;

    always #5 clk = ~clk;

    sdf_bf8_stage dut (
        .clk     (clk),
        .rst     (rst),
        .state_i (state_i),
        .a_r     (a_r),
        .a_i     (a_i),
        .wn_r    (wn_r),
        .wn_i    (wn_i),
        .dout_r  (dout_r),
        .dout_i  (dout_i),
        .valid_o (valid_o),
        .idx_o   (idx_o),
        .ovf_o   (ovf_o),
        .err_o   (err_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_qr[$], m_qi[$];
    int m_fill, m_prev, m_idx, m_dr, m_di;
    bit m_valid, m_ovf, m_err;

    function automatic int reduce(input int v);
`ifdef BF8_SAT_EN
        if (v > 8191)  begin m_ovf = 1'b1; return 8191;  end
        if (v < -8192) begin m_ovf = 1'b1; return -8192; end
        return v;
`else
        return ((v % 16384) + 16384 + 8192) % 16384 - 8192;
`endif
    endfunction

    // Round half up, then divide by 64 (floor).
    function automatic int round64(input int p);
        return (p + 32) >>> 6;
    endfunction

    task automatic model_reset();
        m_qr = {};
        m_qi = {};
        for (int k = 0; k < 8; k++) begin
            m_qr.push_back(0);
            m_qi.push_back(0);
        end
        m_fill = 0; m_prev = S_IDLE; m_idx = 0; m_dr = 0; m_di = 0;
        m_valid = 0; m_ovf = 0; m_err = 0;
    endtask

    task automatic model_step(input int st, input int ar, input int ai,
                              input int wr, input int wi);
        int hr, hi, pr, pi;
        bit nv;
        hr = m_qr[0];
        hi = m_qi[0];
        pr = ar;
        pi = ai;
        if (st == S_FIRST && m_fill < 8) m_err = 1'b1;
        if (st == S_SECOND && m_prev != S_FIRST && m_prev != S_SECOND) m_err = 1'b1;
        nv = (st == S_FIRST) || (st == S_SECOND);
        m_dr = 0;
        m_di = 0;
        if (st == S_FIRST) begin
            m_dr = reduce(hr + ar);
            m_di = reduce(hi + ai);
            pr   = reduce(hr - ar);
            pi   = reduce(hi - ai);
        end else if (st == S_SECOND) begin
            m_dr = reduce(round64(hr * wr - hi * wi));
            m_di = reduce(round64(hr * wi + hi * wr));
        end
        if (st == S_IDLE) begin
            m_fill = 0;
        end else begin
            void'(m_qr.pop_front());
            void'(m_qi.pop_front());
            m_qr.push_back(pr);
            m_qi.push_back(pi);
            if (m_fill < 8) m_fill++;
        end
        m_idx   = nv ? (m_valid ? (m_idx + 1) % 16 : 0) : 0;
        m_valid = nv;
        m_prev  = st;
    endtask

    // ---------------- capture of DUT outputs ----------------
    int cap_r[64], cap_i[64], cap_v[64], cap_x[64];
    int cap_n;

    task automatic cyc(input bit r, input int st, input int ar, input int ai,
                       input int wr, input int wi);
        rst     = r;
        state_i = 2'(st);
        a_r     = DW'(ar);
        a_i     = DW'(ai);
        wn_r    = TW'(wr);
        wn_i    = TW'(wi);
        if (r) model_reset();
        else   model_step(st, ar, ai, wr, wi);
        @(posedge clk);
        #1;
        check("dout_r", $signed(dout_r), m_dr);
        check("dout_i", $signed(dout_i), m_di);
        check("valid",  valid_o, m_valid);
        check("idx",    idx_o,   m_idx);
        check("ovf",    ovf_o,   m_ovf);
        check("err",    err_o,   m_err);
        if (cap_n < 64) begin
            cap_r[cap_n] = $signed(dout_r);
            cap_i[cap_n] = $signed(dout_i);
            cap_v[cap_n] = int'(valid_o);
            cap_x[cap_n] = int'(idx_o);
        end
        cap_n++;
    endtask

    // ---------------- stimulus helpers ----------------
    int fr_r[16], fr_i[16], nx_r[8], nx_i[8];
    int tab_r[8] = '{64, 45, 0, -46, -64, -46, 0, 45};
    int tab_i[8] = '{0, -46, -64, -46, 0, 45, 64, 45};

    function automatic int rdat();
        return int'($urandom_range(0, 16383)) - 8192;
    endfunction

    function automatic int rtw();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++)
            cyc(1'b1, int'($urandom_range(0, 3)), rdat(), rdat(), rtw(), rtw());
    endtask

    task automatic do_wait();
        for (int n = 0; n < 8; n++) cyc(1'b0, S_WAIT, fr_r[n], fr_i[n], rtw(), rtw());
    endtask

    task automatic do_first();
        for (int n = 8; n < 16; n++) cyc(1'b0, S_FIRST, fr_r[n], fr_i[n], rtw(), rtw());
    endtask

    task automatic do_second(input bit use_tab, input bit b2b, input int ncyc);
        for (int k = 0; k < ncyc; k++)
            cyc(1'b0, S_SECOND, b2b ? nx_r[k] : 0, b2b ? nx_i[k] : 0,
                use_tab ? tab_r[k] : rtw(), use_tab ? tab_i[k] : rtw());
    endtask

    task automatic ramp_setup();
        for (int n = 0; n < 16; n++) begin
            fr_r[n] = n + 1;
            fr_i[n] = 0;
        end
    endtask

    task automatic ramp_frame_check(input string pfx);
        ramp_setup();
        cap_n = 0;
        do_wait();
        do_first();
        do_second(1'b1, 1'b0, 8);
        cyc(1'b0, S_IDLE, 0, 0, 0, 0);
        for (int n = 0; n < 8; n++) begin
            check({pfx, "_g_r"}, cap_r[8 + n], 10 + 2 * n);
            check({pfx, "_g_i"}, cap_i[8 + n], 0);
        end
        check({pfx, "_h0_r"}, cap_r[16], -8);
        check({pfx, "_h0_i"}, cap_i[16], 0);
        check({pfx, "_h1_r"}, cap_r[17], -6);
        check({pfx, "_h1_i"}, cap_i[17], 6);
        check({pfx, "_h2_r"}, cap_r[18], 0);
        check({pfx, "_h2_i"}, cap_i[18], 8);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit b2b;
        int vcount;
        model_reset();
        cap_n = 0;

        // 1: reset with random inputs
        do_reset(2);
        check("s1_dout_r", $signed(dout_r), 0);
        check("s1_dout_i", $signed(dout_i), 0);
        check("s1_valid", valid_o, 0);
        check("s1_idx", idx_o, 0);
        check("s1_ovf", ovf_o, 0);
        check("s1_err", err_o, 0);

        // 2: real ramp with controller twiddles
        ramp_frame_check("s2");
        check("s2_err", err_o, 0);

        // 3: full-scale constant input
        do_reset(1);
        for (int n = 0; n < 16; n++) begin
            fr_r[n] = 8191;
            fr_i[n] = 0;
        end
        cap_n = 0;
        do_wait();
        do_first();
        do_second(1'b1, 1'b0, 8);
        for (int n = 0; n < 8; n++) begin
`ifdef BF8_SAT_EN
            check("s3_g_sat", cap_r[8 + n], 8191);
`else
            check("s3_g_wrap", cap_r[8 + n], -2);
`endif
            check("s3_h", cap_r[16 + n], 0);
        end
`ifdef BF8_SAT_EN
        check("s3_ovf", ovf_o, 1);
`else
        check("s3_ovf", ovf_o, 0);
`endif

        // 4: two frames back-to-back, no bubble, then SECOND -> WAITING
        do_reset(1);
        for (int n = 0; n < 16; n++) begin
            fr_r[n] = rdat();
            fr_i[n] = rdat();
        end
        for (int k = 0; k < 8; k++) begin
            nx_r[k] = rdat();
            nx_i[k] = rdat();
        end
        cap_n = 0;
        do_wait();
        do_first();
        do_second(1'b1, 1'b1, 8);
        for (int n = 0; n < 8; n++) begin
            fr_r[n + 8] = rdat();
            fr_i[n + 8] = rdat();
        end
        do_first();
        do_second(1'b1, 1'b0, 8);
        cyc(1'b0, S_WAIT, rdat(), rdat(), rtw(), rtw());
        vcount = 0;
        for (int k = 8; k < 40; k++) begin
            vcount += cap_v[k];
            check("s4_idx", cap_x[k], (k - 8) % 16);
        end
        check("s4_valid_count", vcount, 32);
        check("s4_no_spurious", cap_v[40], 0);
        check("s4_err", err_o, 0);

        // 5: FIRST after only 5 WAITING cycles
        do_reset(1);
        for (int n = 0; n < 5; n++) cyc(1'b0, S_WAIT, rdat(), rdat(), rtw(), rtw());
        cyc(1'b0, S_FIRST, rdat(), rdat(), rtw(), rtw());
        check("s5_err", err_o, 1);
        for (int n = 0; n < 4; n++)
            cyc(1'b0, int'($urandom_range(0, 3)), rdat(), rdat(), rtw(), rtw());
        check("s5_err_sticky", err_o, 1);

        // 6: reset mid-SECOND, then a clean ramp frame
        do_reset(1);
        ramp_setup();
        do_wait();
        do_first();
        do_second(1'b1, 1'b0, 3);
        do_reset(1);
        ramp_frame_check("s6");
        check("s6_err", err_o, 0);

        // 7: random legal frames, back-to-back or with gaps
        do_reset(1);
        for (int n = 0; n < 16; n++) begin
            fr_r[n] = rdat();
            fr_i[n] = rdat();
        end
        do_wait();
        for (int f = 0; f < 20; f++) begin
            do_first();
            b2b = 1'($urandom_range(0, 1));
            for (int k = 0; k < 8; k++) begin
                nx_r[k] = rdat();
                nx_i[k] = rdat();
            end
            do_second(1'b0, b2b, 8);
            for (int n = 0; n < 16; n++) begin
                fr_r[n] = (b2b && n < 8) ? nx_r[n] : rdat();
                fr_i[n] = (b2b && n < 8) ? nx_i[n] : rdat();
            end
            if (!b2b) begin
                repeat (int'($urandom_range(0, 2))) cyc(1'b0, S_IDLE, rdat(), rdat(), rtw(), rtw());
                do_wait();
            end
        end
        check("s7_err", err_o, 0);

        // 8: unconstrained random states with occasional reset
        for (int n = 0; n < 300; n++)
            cyc($urandom_range(0, 31) == 0, int'($urandom_range(0, 3)),
                rdat(), rdat(), rtw(), rtw());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
